// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle sequencer: FSM states,
// instruction field constants and ALU operation codes.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLT = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_XOR = 3'b100;
    localparam logic [2:0] ULA_SLT = 3'b101;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of a 32-bit instruction word into ALU controls,
// write enable and an illegal-encoding flag.
module instr_decode
    import multicycle_pkg::*;
(
    input  logic [31:0] ir,
    output logic [2:0]  ula_control,
    output logic        ula_src,
    output logic        wr_en,
    output logic        illegal
);

    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign op     = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        // Anything not matched below falls through as illegal with neutral controls.
        ula_control = ULA_ADD;
        ula_src     = 1'b0;
        wr_en       = 1'b0;
        illegal     = 1'b1;
        if (op == OP_R) begin
            if (funct7 == F7_BASE) begin
                illegal = 1'b0;
                wr_en   = 1'b1;
                case (funct3)
                    F3_ADD:  ula_control = ULA_ADD;
                    F3_AND:  ula_control = ULA_AND;
                    F3_OR:   ula_control = ULA_OR;
                    F3_XOR:  ula_control = ULA_XOR;
                    F3_SLT:  ula_control = ULA_SLT;
                    default: begin
                        illegal = 1'b1;
                        wr_en   = 1'b0;
                    end
                endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                ula_control = ULA_SUB;
                illegal     = 1'b0;
                wr_en       = 1'b1;
            end
        end else if (op == OP_I && funct3 == F3_ADD) begin
            ula_control = ULA_ADD;
            ula_src     = 1'b1;
            illegal     = 1'b0;
            wr_en       = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetches over req/ack, decodes, and steps
// each instruction through FETCH/DECODE/EXEC/WB, owning PC and status counters.
module multicycle_sequencer
    import multicycle_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      ULAControl,
    output logic            ULASrc,
    output logic            RegWrite,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [11:0]     imm,
    output logic            busy,
    output logic            illegal,
    output logic [15:0]     retired
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic        wr_q;

    logic [2:0]  dec_control;
    logic        dec_src;
    logic        dec_wr;
    logic        dec_illegal;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    instr_decode u_decode (
        .ir          (ir),
        .ula_control (dec_control),
        .ula_src     (dec_src),
        .wr_en       (dec_wr),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        busy       = 1'b1;
        RegWrite   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB: begin
                RegWrite   = wr_q;
                state_next = run ? S_FETCH : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir         <= '0;
            pc         <= RESET_PC;
            ULAControl <= ULA_ADD;
            ULASrc     <= 1'b0;
            wr_q       <= 1'b0;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            imm        <= '0;
            illegal    <= 1'b0;
            retired    <= '0;
        end else begin
            if (state == S_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            // Controls and fields are captured once here and held through WB.
            if (state == S_DECODE) begin
                ULAControl <= dec_control;
                ULASrc     <= dec_src;
                wr_q       <= dec_wr;
                rs1        <= ir[19:15];
                rs2        <= ir[24:20];
                rd         <= ir[11:7];
                imm        <= ir[31:20];
                if (dec_illegal) illegal <= 1'b1;
            end
            if (state == S_WB) begin
                pc <= pc + PC_STEP;
                if (wr_q) retired <= sat_inc(retired);
            end
        end
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle instruction sequencer for the sprint datapath. It fetches 32-bit instructions from instruction memory over a req/ack handshake, decodes them, and sequences each one through fixed FETCH, DECODE, EXEC and WB steps. In each step it drives the ALU controls (ULAControl, ULASrc) and the register-file write enable (RegWrite). It owns the PC, a sticky illegal-instruction flag and a retired-instruction counter.

## Interface
Parameters:
- PC_W, 8, PC width in bits. Byte address, step 4.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset, synchronous and active-high.
- run  in  1  level enable. Sampled only in IDLE and at WB exit.
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- imem_req  out  1  fetch request for address pc.
- pc  out  PC_W  current instruction address.
- ULAControl  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- ULASrc  out  1  0 = rs2 operand, 1 = immediate operand.
- RegWrite  out  1  register-file write strobe.
- rs1, rs2, rd  out  5 each  IR[19:15], IR[24:20], IR[11:7].
- imm  out  12  IR[31:20].
- busy  out  1  high in any state other than IDLE.
- illegal  out  1  sticky; set on the first undecodable instruction.
- retired  out  16  count of legal instructions written back.

## Operation
- States: IDLE → FETCH → DECODE → EXEC → WB → (FETCH | IDLE).
- IDLE:
  - all strobes low.
  - run=1 moves to FETCH on the next cycle.
- FETCH:
  - imem_req=1, decoded from state.
  - Stay in FETCH until imem_ack=1.
  - On ack: IR ← imem_rdata, go to DECODE.
  - An ack in the first FETCH cycle is legal.
  - imem_ack is ignored in every other state.
- DECODE (fields are OP=IR[6:0], funct3=IR[14:12], funct7=IR[31:25]):
  - R-type, OP 0110011, matched on funct3/funct7:
    - ADD 000/0000000
    - SUB 000/0100000
    - AND 111/0000000
    - OR 110/0000000
    - XOR 100/0000000
    - SLT 010/0000000
  - ADDI: OP 0010011 and funct3 000; funct7 is don't-care. Gives ULASrc=1, ULAControl=000.
  - Any other encoding is illegal: set illegal, force ULAControl=000 and ULASrc=0, and suppress the write.
  - Decoded controls are registered at DECODE exit.
- EXEC: controls held stable, RegWrite=0.
- WB:
  - RegWrite=1 for one cycle if the instruction is legal.
  - pc ← pc+4, wrapping mod 2^PC_W.
  - retired increments (legal instructions only) and saturates at 0xFFFF.
  - Next state: run=1 → FETCH, run=0 → IDLE.
- run falling mid-instruction does not abort it; the instruction completes through WB.
- illegal clears only on rst.

## Timing
- Reset values:
  - state IDLE
  - pc=RESET_PC
  - IR, rs1, rs2, rd, imm = 0
  - ULAControl=000, ULASrc=0, RegWrite=0
  - imem_req=0, busy=0, illegal=0, retired=0
- Reset in any state takes effect on the next edge. imem_req drops in that cycle, and a pending fetch is abandoned (its later ack is ignored).
- Zero-wait memory: 4 cycles per instruction. Each wait cycle extends FETCH by one.
- ULAControl, ULASrc, rs1, rs2, rd and imm are valid from the first EXEC cycle through the WB cycle. They are unchanged until the next DECODE exit.
- pc updates on the WB exit edge. During FETCH, pc is the address being fetched.
- RegWrite is never high outside WB and never high for two consecutive cycles.

## Structure
- Shared package multicycle_pkg holds:
  - the state enum
  - OP constants (OP_R=0110011, OP_I=0010011)
  - funct3/funct7 constants
  - ULAControl encodings, used by ALU and sequencer alike
- Sub-module instr_decode: combinational decode of the 32-bit IR to {ULAControl, ULASrc, wr_en, illegal}. The FSM, PC and counters stay in the top module.

## Test plan
- Reset, then run=1, imem_rdata=0x002081B3 (ADD x3,x1,x2), ack in the first FETCH cycle → RegWrite pulses in cycle 4, ULAControl=000, rd=3, pc=4 afterwards, retired=1.
- ADDI x5,x0,-1 (0xFFF00293) with a 3-cycle ack delay → ULASrc=1, imm=0xFFF, RegWrite in cycle 7, pc=4.
- Back-to-back SUB (0x40208133), AND, OR, XOR, SLT → ULAControl sequence 001, 010, 011, 100, 101; one RegWrite per 4 cycles.
- Illegal word 0x00000000 → illegal=1, no RegWrite, retired unchanged, pc advances by 4. A following ADD executes normally and illegal stays 1.
- rst asserted during FETCH, before ack → next cycle IDLE, imem_req=0, pc=RESET_PC. A late ack is ignored.
- pc=0xFC with PC_W=8 → after WB pc=0x00. run dropped during EXEC → instruction completes, then IDLE with busy=0.
